pc_update: RTL and testbench
============================

PC_UPDATE -- requirements
Module: pc_update

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port `stall`, input, 1 bit: hold PC and state this cycle.
REQ-004 SHALL have port `halt_op`, input, 1 bit: fetched instruction is HLT.
REQ-005 SHALL have port `branch`, input, 1 bit: conditional PC-relative branch (B).
REQ-006 SHALL have port `br_reg`, input, 1 bit: conditional register-indirect branch (BR); see REQ-026.
REQ-007 SHALL have port `cond`, input, 3 bits: branch condition code.
REQ-008 SHALL have port `flags`, input, 3 bits: {Z,V,N}, where [2]=Z, [1]=V, [0]=N.
REQ-009 SHALL have port `offset`, input, 9 bits: signed word offset for B.
REQ-010 SHALL have port `reg_target`, input, 16 bits: target address for BR.
REQ-011 SHALL have port `pc`, output, 16 bits: current fetch address (registered).
REQ-012 SHALL have port `pc_plus2`, output, 16 bits: pc+2 (combinational), supplied to the link/PCS path.
REQ-013 SHALL have port `taken`, output, 1 bit: redirect this cycle (combinational).
REQ-014 SHALL have port `flush`, output, 1 bit: registered; squashes the IF/ID stage the cycle after a redirect.
REQ-015 SHALL have port `halted`, output, 1 bit: registered; high in HALT state.

Function
REQ-016 SHALL compute pc_plus2 as pc+16'd2 using the team's 16-bit CLA adder, with wrap modulo 2^16 (0xFFFE -> 0x0000).
REQ-017 SHALL compute the B target as pc_plus2 + (sign-extended offset << 1), using a second 16-bit CLA adder with cin=0 and carry discarded (wraps).
REQ-018 SHALL evaluate cond as follows: 000 NE (!Z); 001 EQ (Z); 010 GT (!Z & !N); 011 LT (N); 100 GE (Z | (!Z & !N)); 101 LE (N | Z); 110 OV (V); 111 UNC (1).
REQ-019 SHALL drive taken=1 only when in RUN, !stall, !halt_op, (branch|br_reg), and the condition is true.
REQ-020 SHALL use two states, RUN and HALT; RUN goes to HALT when halt_op & !stall; HALT exits only via rst.
REQ-021 SHALL set next pc in RUN with priority: stall -> hold; halt_op -> hold; taken & br_reg -> reg_target; taken & branch -> B target; else pc_plus2.
REQ-022 SHALL give br_reg priority over branch when both are asserted.
REQ-023 SHALL hold pc and drive taken=0 in HALT regardless of any input.
REQ-024 SHALL register flush as taken from the prior cycle, so flush is a 1-cycle pulse; flush SHALL be 0 while stall holds the pipeline.
REQ-025 SHALL give a new pc value a latency of 1 cycle from the deciding inputs.

Configuration
REQ-026 SHALL compile in BR support under macro PC_BR_REG_EN: when defined, br_reg acts per REQ-021; when undefined, br_reg and reg_target are ignored, and only B and sequential flow exist.

Reset
REQ-027 SHALL on rst=1 at a rising edge set pc=0x0000, flush=0, halted=0, and state=RUN; rst SHALL override stall, halt_op, and branches, including mid-HALT or mid-redirect.

Verification
REQ-028 SHALL cover sequential flow: reset, then 3 cycles with no control -> pc 0x0000, 0x0002, 0x0004, 0x0006.
REQ-029 SHALL cover B with wrap: pc=0xFFFC, branch=1, cond=111, offset=9'h1FF (-1) -> next pc=0xFFFC, taken=1, flush=1 the next cycle.
REQ-030 SHALL cover the conditions: flags Z=1 with cond=000 -> not taken, pc+2; same flags with cond=001, offset=4 -> pc+2+8.
REQ-031 SHALL cover stall: stall=1 with branch true -> pc held, taken=0, no flush.
REQ-032 SHALL cover halt: halt_op=1 at pc=0x0010 -> pc stays 0x0010, halted=1 next cycle; later branch ignored; rst -> pc=0, halted=0.
REQ-033 SHALL cover BR under PC_BR_REG_EN: br_reg=1, branch=1, cond=111, reg_target=0x1234 -> next pc=0x1234; without the macro -> B target.

Source files
------------

// File: rtl/pc_update.sv
// Program counter update unit: sequential fetch, conditional PC-relative (B) and
// register-indirect (BR, only when PC_BR_REG_EN is defined) redirects, and HLT.
module pc_update (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        halt_op,
  input  logic        branch,
  input  logic        br_reg,
  input  logic [2:0]  cond,
  input  logic [2:0]  flags,
  input  logic [8:0]  offset,
  input  logic [15:0] reg_target,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        taken,
  output logic        flush,
  output logic        halted
);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HALT = 1'b1;

  logic [0:0]  r_state;
  logic [15:0] r_pc;
  logic        r_flush;

  logic [0:0]  w_state_next;
  logic [15:0] w_pc_next;
  logic [15:0] w_pc_plus2;
  logic [15:0] w_off_ext;
  logic [15:0] w_b_target;
  logic        w_cond_true;
  logic        w_br_sel;
  logic        w_branch_req;
  logic        w_taken;
  logic        w_unused_cout_inc;
  logic        w_unused_cout_tgt;
  logic        w_flag_z;
  logic        w_flag_v;
  logic        w_flag_n;

`ifdef PC_BR_REG_EN
  assign w_br_sel = br_reg;
`else
  // Without BR support the register-indirect inputs are intentionally dead.
  logic w_unused_br;
  assign w_unused_br = ^{br_reg, reg_target};
  assign w_br_sel    = 1'b0;
`endif

  assign w_flag_z = flags[2];
  assign w_flag_v = flags[1];
  assign w_flag_n = flags[0];

  pc_update_cla16 u_inc (
    .a    (r_pc),
    .b    (16'd2),
    .cin  (1'b0),
    .sum  (w_pc_plus2),
    .cout (w_unused_cout_inc)
  );

  // Word offset: sign-extend 9 bits and scale by 2 bytes.
  assign w_off_ext = {{6{offset[8]}}, offset, 1'b0};

  pc_update_cla16 u_tgt (
    .a    (w_pc_plus2),
    .b    (w_off_ext),
    .cin  (1'b0),
    .sum  (w_b_target),
    .cout (w_unused_cout_tgt)
  );

  always_comb begin
    w_cond_true = 1'b0;
    case (cond)
      3'b000:  w_cond_true = !w_flag_z;
      3'b001:  w_cond_true = w_flag_z;
      3'b010:  w_cond_true = !w_flag_z && !w_flag_n;
      3'b011:  w_cond_true = w_flag_n;
      3'b100:  w_cond_true = w_flag_z || (!w_flag_z && !w_flag_n);
      3'b101:  w_cond_true = w_flag_n || w_flag_z;
      3'b110:  w_cond_true = w_flag_v;
      default: w_cond_true = 1'b1;
    endcase
  end

  assign w_branch_req = branch || w_br_sel;
  assign w_taken      = (r_state == S_RUN) && !stall && !halt_op &&
                        w_branch_req && w_cond_true;

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    if (r_state == S_RUN) begin
      if (stall) begin
        w_pc_next = r_pc;
      end else if (halt_op) begin
        w_state_next = S_HALT;
        w_pc_next    = r_pc;
      end else if (w_taken && w_br_sel) begin
        w_pc_next = reg_target;
      end else if (w_taken) begin
        w_pc_next = w_b_target;
      end else begin
        w_pc_next = w_pc_plus2;
      end
    end
  end

  // taken is already forced low by stall and HALT, so flush inherits that.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_pc    <= 16'h0000;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_flush <= w_taken;
    end
  end

  assign pc       = r_pc;
  assign pc_plus2 = w_pc_plus2;
  assign taken    = w_taken;
  assign flush    = r_flush;
  assign halted   = (r_state == S_HALT);

endmodule

// Two-level carry-lookahead adder: four 4-bit CLA groups plus a group carry unit.
module pc_update_cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [3:0] w_gp;
  logic [3:0] w_gg;
  logic [3:0] w_c;

  assign w_c[0] = cin;
  assign w_c[1] = w_gg[0] | (w_gp[0] & cin);
  assign w_c[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & cin);
  assign w_c[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0]) |
                  (w_gp[2] & w_gp[1] & w_gp[0] & cin);
  assign cout   = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1]) |
                  (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0]) |
                  (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & cin);

  for (genvar gi = 0; gi < 4; gi++) begin : g_blk
    pc_update_cla4 u_cla4 (
      .a   (a[gi*4 +: 4]),
      .b   (b[gi*4 +: 4]),
      .cin (w_c[gi]),
      .sum (sum[gi*4 +: 4]),
      .pg  (w_gp[gi]),
      .gg  (w_gg[gi])
    );
  end

endmodule

// 4-bit carry-lookahead block exporting group propagate/generate.
module pc_update_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       pg,
  output logic       gg
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [3:0] w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0]) |
                  (w_p[2] & w_p[1] & w_p[0] & cin);

  assign sum = w_p ^ w_c;
  assign pg  = &w_p;
  assign gg  = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1]) |
               (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

endmodule

// File: tb/tb_pc_update.sv
// Bench for pc_update: table of vectors with hand-derived expectations, plus a
// short BR sequence whose expectations depend on PC_BR_REG_EN.
module tb_pc_update;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        halt_op;
  logic        branch;
  logic        br_reg;
  logic [2:0]  cond;
  logic [2:0]  flags;
  logic [8:0]  offset;
  logic [15:0] reg_target;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        taken;
  logic        flush;
  logic        halted;

  always #5 clk = ~clk;

  pc_update dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .halt_op    (halt_op),
    .branch     (branch),
    .br_reg     (br_reg),
    .cond       (cond),
    .flags      (flags),
    .offset     (offset),
    .reg_target (reg_target),
    .pc         (pc),
    .pc_plus2   (pc_plus2),
    .taken      (taken),
    .flush      (flush),
    .halted     (halted)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        halt_op;
    logic        branch;
    logic        br_reg;
    logic [2:0]  cond;
    logic [2:0]  flags;
    logic [8:0]  offset;
    logic [15:0] reg_target;
    logic        exp_taken;
    logic [15:0] exp_pc;
    logic        exp_flush;
    logic        exp_halted;
  } vec_t;

  vec_t        vecs[$];
  logic [17:0] exp_q[$];
  logic [15:0] cur_pc;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic st, input logic h, input logic b,
                     input logic [2:0] c, input logic [2:0] f, input logic [8:0] o,
                     input logic et, input logic [15:0] ep, input logic ef,
                     input logic eh);
    vec_t v;
    v.rst = r; v.stall = st; v.halt_op = h; v.branch = b; v.br_reg = 1'b0;
    v.cond = c; v.flags = f; v.offset = o;
    v.reg_target = 16'($urandom_range(0, 16'hFFFF));
    v.exp_taken = et; v.exp_pc = ep; v.exp_flush = ef; v.exp_halted = eh;
    vecs.push_back(v);
  endtask

  // Drive at negedge, check combinational outputs, then score registered outputs.
  task automatic apply(input vec_t v, input string tag);
    logic [17:0] e;
    @(negedge clk);
    rst = v.rst; stall = v.stall; halt_op = v.halt_op; branch = v.branch;
    br_reg = v.br_reg; cond = v.cond; flags = v.flags; offset = v.offset;
    reg_target = v.reg_target;
    exp_q.push_back({v.exp_pc, v.exp_flush, v.exp_halted});
    #1;
    chk({tag, ".taken"}, {15'd0, taken}, {15'd0, v.exp_taken});
    chk({tag, ".pc_plus2"}, pc_plus2, cur_pc + 16'd2);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL %s.queue actual=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".pc"}, pc, e[17:2]);
      chk({tag, ".flush"}, {15'd0, flush}, {15'd0, e[1]});
      chk({tag, ".halted"}, {15'd0, halted}, {15'd0, e[0]});
      cur_pc = e[17:2];
    end
  endtask

  initial begin
    vec_t v;
    logic br_en;
`ifdef PC_BR_REG_EN
    br_en = 1'b1;
`else
    br_en = 1'b0;
`endif
    rst = 1'b1; stall = 1'b0; halt_op = 1'b0; branch = 1'b0; br_reg = 1'b0;
    cond = 3'b000; flags = 3'b000; offset = 9'd0; reg_target = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.pc", pc, 16'h0000);
    chk("reset.flush", {15'd0, flush}, 16'd0);
    chk("reset.halted", {15'd0, halted}, 16'd0);
    cur_pc = 16'h0000;

    //  rst st  h   b   cond    flags   offset   tk  pc        fl  hl
    add(0, 0, 0, 0, 3'b000, 3'b000, 9'd0,    0, 16'h0002, 0, 0);
    add(0, 0, 0, 0, 3'b000, 3'b000, 9'd0,    0, 16'h0004, 0, 0);
    add(0, 0, 0, 0, 3'b000, 3'b000, 9'd0,    0, 16'h0006, 0, 0);
    add(0, 0, 0, 1, 3'b000, 3'b100, 9'd4,    0, 16'h0008, 0, 0);
    add(0, 0, 0, 1, 3'b001, 3'b100, 9'd4,    1, 16'h0012, 1, 0);
    add(0, 0, 0, 0, 3'b111, 3'b000, 9'd0,    0, 16'h0014, 0, 0);
    add(0, 0, 0, 1, 3'b010, 3'b000, 9'h1FE,  1, 16'h0012, 1, 0);
    add(0, 0, 0, 1, 3'b011, 3'b000, 9'd8,    0, 16'h0014, 0, 0);
    add(0, 0, 0, 1, 3'b011, 3'b001, 9'd8,    1, 16'h0026, 1, 0);
    add(0, 0, 0, 1, 3'b100, 3'b001, 9'd8,    0, 16'h0028, 0, 0);
    add(0, 0, 0, 1, 3'b101, 3'b001, 9'd1,    1, 16'h002C, 1, 0);
    add(0, 0, 0, 1, 3'b110, 3'b000, 9'd1,    0, 16'h002E, 0, 0);
    add(0, 0, 0, 1, 3'b110, 3'b010, 9'd0,    1, 16'h0030, 1, 0);
    add(0, 1, 0, 1, 3'b111, 3'b000, 9'd5,    0, 16'h0030, 0, 0);
    add(0, 0, 0, 1, 3'b111, 3'b000, 9'h100,  1, 16'hFE32, 1, 0);
    add(0, 0, 0, 0, 3'b111, 3'b000, 9'd0,    0, 16'hFE34, 0, 0);
    add(0, 0, 0, 1, 3'b111, 3'b000, 9'd227,  1, 16'hFFFC, 1, 0);
    add(0, 0, 0, 1, 3'b111, 3'b000, 9'h1FF,  1, 16'hFFFC, 1, 0);
    add(0, 0, 0, 0, 3'b000, 3'b000, 9'd0,    0, 16'hFFFE, 0, 0);
    add(0, 0, 0, 0, 3'b000, 3'b000, 9'd0,    0, 16'h0000, 0, 0);
    add(0, 0, 0, 1, 3'b111, 3'b000, 9'd7,    1, 16'h0010, 1, 0);
    add(0, 0, 1, 1, 3'b111, 3'b000, 9'd7,    0, 16'h0010, 0, 1);
    add(0, 0, 0, 1, 3'b111, 3'b000, 9'd5,    0, 16'h0010, 0, 1);
    add(0, 0, 0, 0, 3'b000, 3'b000, 9'd0,    0, 16'h0010, 0, 1);
    add(1, 0, 0, 1, 3'b111, 3'b000, 9'd5,    0, 16'h0000, 0, 0);
    add(0, 0, 0, 0, 3'b000, 3'b000, 9'd0,    0, 16'h0002, 0, 0);
    add(0, 1, 1, 0, 3'b000, 3'b000, 9'd0,    0, 16'h0002, 0, 0);
    add(1, 0, 0, 1, 3'b111, 3'b000, 9'd5,    1, 16'h0000, 0, 0);
    add(0, 0, 0, 0, 3'b000, 3'b000, 9'd0,    0, 16'h0002, 0, 0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // BR sequence, starting at pc 0x0002 with flush low.
    v = vecs[0];
    v.br_reg = 1'b1; v.branch = 1'b1; v.cond = 3'b111; v.offset = 9'd3;
    v.reg_target = 16'h1234; v.exp_taken = 1'b1;
    v.exp_pc = br_en ? 16'h1234 : 16'h000A; v.exp_flush = 1'b1;
    apply(v, "br_both");

    v.branch = 1'b0; v.reg_target = 16'h2000;
    v.exp_taken = br_en; v.exp_flush = br_en;
    v.exp_pc = br_en ? 16'h2000 : cur_pc + 16'd2;
    apply(v, "br_only");

    v.cond = 3'b000; v.flags = 3'b100; v.reg_target = 16'h3000;
    v.exp_taken = 1'b0; v.exp_flush = 1'b0; v.exp_pc = cur_pc + 16'd2;
    apply(v, "br_nottaken");

    v.stall = 1'b1; v.cond = 3'b111; v.reg_target = 16'h4000;
    v.exp_taken = 1'b0; v.exp_flush = 1'b0; v.exp_pc = cur_pc;
    apply(v, "br_stall");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout actual=running expected=done");
    $fatal(1);
  end

endmodule
